truth_table_scanner: RTL and testbench

- Sequential stimulus/response engine for the team's small combinational gate modules.
- Sweeps every input combination of an external N-input, 1-output combinational function and samples its output after a settle delay.
- Assembles the measured truth table and compares it against an expected table.
- Sits between control logic or a bench top and any gate-level function under test, replacing hand-written stimulus sequences.

---
 rtl/truth_table_scanner.sv | 153 +++++++++++++++
 tb/tb_truth_table_scanner.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: sweeps all 2**N_IN rows of a 1-output function and grades it.
// Optional macro TT_XCHECK_EN: x/z samples set x_seen and count as mismatches.
module truth_table_scanner #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
    output logic                 pass,
    output logic [N_IN:0]        mismatch_cnt,
    output logic [N_IN-1:0]      first_err_idx,
    output logic                 x_seen
);

    localparam int ROWS = 2**N_IN;
    localparam logic [N_IN-1:0] LAST = N_IN'(ROWS - 1);
    localparam logic [3:0] SETTLE_LAST = 4'((SETTLE > 0) ? SETTLE - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE_W,
        SAMPLE,
        FINISH
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [N_IN-1:0] idx;
    logic [3:0]      cnt;
    logic            accept;
    logic            smp_x;
    logic            smp_bit;
    logic            smp_miss;

    // done is still high in the first IDLE cycle, so a start there is dropped
    assign accept = (state == IDLE) && start && !done;
    assign dut_in = idx;

`ifdef TT_XCHECK_EN
    assign smp_x = (dut_out !== 1'b0) && (dut_out !== 1'b1);
`else
    assign smp_x = 1'b0;
`endif

    assign smp_bit  = smp_x ? 1'b0 : dut_out;
    assign smp_miss = smp_x || (dut_out != expected[idx]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = (SETTLE == 0) ? SAMPLE : SETTLE_W;
                end
            end
            SETTLE_W: begin
                if (cnt == SETTLE_LAST) begin
                    state_nx = SAMPLE;
                end
            end
            SAMPLE: begin
                if (idx == LAST) begin
                    state_nx = FINISH;
                end else begin
                    state_nx = (SETTLE == 0) ? SAMPLE : SETTLE_W;
                end
            end
            FINISH: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx           <= '0;
            cnt           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            table_out     <= '0;
            pass          <= 1'b0;
            mismatch_cnt  <= '0;
            first_err_idx <= '0;
            x_seen        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        idx           <= '0;
                        cnt           <= '0;
                        busy          <= 1'b1;
                        table_out     <= '0;
                        pass          <= 1'b0;
                        mismatch_cnt  <= '0;
                        first_err_idx <= '0;
                        x_seen        <= 1'b0;
                    end
                end
                SETTLE_W: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    table_out[idx] <= smp_bit;
                    cnt            <= '0;
                    if (smp_x) begin
                        x_seen <= 1'b1;
                    end
                    if (smp_miss) begin
                        mismatch_cnt <= mismatch_cnt + 1'b1;
                        if (mismatch_cnt == '0) begin
                            first_err_idx <= idx;
                        end
                    end
                    // index parks on the last row so dut_in holds all ones
                    if (idx != LAST) begin
                        idx <= idx + 1'b1;
                    end
                end
                FINISH: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    pass <= (mismatch_cnt == '0);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: random functions and golden tables checked
// against a row-arithmetic model every cycle, plus directed timing/reset cases.
`timescale 1ns/1ps
module tb_truth_table_scanner;

    localparam int N    = 2;
    localparam int S    = 1;
    localparam int ROWS = 1 << N;
    localparam int LAT  = ROWS * (S + 1) + 1;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [ROWS-1:0] expected = '0;
    logic [N-1:0]    dut_in;
    logic            dut_out;
    logic            busy;
    logic            done;
    logic [ROWS-1:0] table_out;
    logic            pass;
    logic [N:0]      mismatch_cnt;
    logic [N-1:0]    first_err_idx;
    logic            x_seen;

    logic [ROWS-1:0] func = '0;
    int              x_row = -1;
    int              tests = 0;
    int              fails = 0;
    int              cyc = 0;
    int              n = -1;
    logic [ROWS-1:0] m_table = '0;
    int              m_cnt = 0;
    int              m_first = 0;
    bit              m_x = 1'b0;

    truth_table_scanner #(.N_IN(N), .SETTLE(S)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .expected      (expected),
        .dut_in        (dut_in),
        .dut_out       (dut_out),
        .busy          (busy),
        .done          (done),
        .table_out     (table_out),
        .pass          (pass),
        .mismatch_cnt  (mismatch_cnt),
        .first_err_idx (first_err_idx),
        .x_seen        (x_seen)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always_comb begin
        dut_out = func[dut_in];
        if (x_row >= 0 && int'(dut_in) == x_row) dut_out = 1'bx;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic predict();
        bit is_x;
        bit got;
        m_table = '0;
        m_cnt   = 0;
        m_first = 0;
        m_x     = 1'b0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            is_x = (i == x_row);
            got  = is_x ? 1'b0 : func[i];
            if (is_x) m_x = 1'b1;
            m_table[i] = got;
            if (is_x || got != expected[i]) begin
                m_cnt++;
                m_first = i;
            end
        end
    endtask

    // n = clock edges since the accepting edge; -1 before any sweep
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = -1;
        end else if (start && (n < 0 || n > LAT)) begin
            n = 0;
            predict();
        end else if (n >= 0 && n <= LAT) begin
            n++;
        end
    end

    always @(negedge clk) begin
        int e_in;
        e_in = (n < 0) ? 0 : (((n / (S + 1)) > ROWS - 1) ? ROWS - 1 : n / (S + 1));
        check("busy", busy, (n >= 0 && n < LAT));
        check("done", done, (n == LAT));
        check("dut_in", dut_in, e_in);
        if (n < 0) begin
            check("table_idle", table_out, 0);
            check("pass_idle", pass, 0);
            check("cnt_idle", mismatch_cnt, 0);
            check("first_idle", first_err_idx, 0);
            check("xseen_idle", x_seen, 0);
        end else if (n >= LAT) begin
            check("table", table_out, m_table);
            check("pass", pass, (m_cnt == 0));
            check("cnt", mismatch_cnt, m_cnt);
            check("first", first_err_idx, m_first);
            check("xseen", x_seen, m_x);
        end
    end

    task automatic run(input logic [ROWS-1:0] f, input logic [ROWS-1:0] e,
                       input bit poke, output int lat);
        int t0;
        bit seen;
        func     = f;
        expected = e;
        start    = 1'b1;
        t0       = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        lat   = -1;
        for (int i = 1; i < 200 && !seen; i++) begin
            if (done) begin
                seen = 1'b1;
                lat  = cyc - t0;
                if (poke) start = 1'b1;
            end else if (poke && i == 3) begin
                start = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
        end
        check("done_seen", seen, 1);
    endtask

    initial begin
        int lat;
        logic [ROWS-1:0] f;
        logic [ROWS-1:0] e;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // s = ~x & y
        run(4'b0010, 4'b0010, 1'b0, lat);
        check("lat_pass", lat, 9);
        check("tt_table", table_out, 4'b0010);
        check("tt_pass", pass, 1);
        check("tt_cnt", mismatch_cnt, 0);
        check("tt_first", first_err_idx, 0);

        repeat (2) @(negedge clk);
        run(4'b0010, 4'b1010, 1'b0, lat);
        check("one_table", table_out, 4'b0010);
        check("one_pass", pass, 0);
        check("one_cnt", mismatch_cnt, 1);
        check("one_first", first_err_idx, 3);

        run(4'b0010, 4'b1101, 1'b1, lat);
        check("lat_poke", lat, 9);
        check("all_cnt", mismatch_cnt, 4);
        check("all_first", first_err_idx, 0);
        check("all_pass", pass, 0);
        repeat (12) @(negedge clk);

        func     = 4'b0110;
        expected = 4'b0110;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 50 && dut_in != 2; i++) @(negedge clk);
        check("reach_row2", dut_in, 2);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dut_in", dut_in, 0);
        check("rst_table", table_out, 0);
        check("rst_cnt", mismatch_cnt, 0);
        check("rst_pass", pass, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        run(4'b0110, 4'b0110, 1'b0, lat);
        check("post_rst_table", table_out, 4'b0110);
        check("post_rst_pass", pass, 1);

        repeat (25) begin
            f = ROWS'($urandom);
            e = ($urandom_range(0, 2) == 0) ? f : ROWS'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run(f, e, bit'($urandom_range(0, 1)), lat);
            check("lat_rand", lat, LAT);
        end

`ifdef TT_XCHECK_EN
        x_row = 1;
        run(4'b0010, 4'b0010, 1'b0, lat);
        check("x_seen", x_seen, 1);
        check("x_cnt", mismatch_cnt, 1);
        check("x_first", first_err_idx, 1);
        check("x_table1", table_out[1], 0);
        x_row = -1;
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
